// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, sequencer FSM encoding and default width
package alu_pkg;

    localparam int REG_SIZE = 8;

    localparam logic [3:0] OP_INC_B  = 4'b0000;
    localparam logic [3:0] OP_OR     = 4'b0001;
    localparam logic [3:0] OP_SUB    = 4'b0010;
    localparam logic [3:0] OP_XOR    = 4'b0011;
    localparam logic [3:0] OP_ONE    = 4'b0100;
    localparam logic [3:0] OP_AND    = 4'b0101;
    localparam logic [3:0] OP_ADD    = 4'b0110;
    localparam logic [3:0] OP_NOT_A  = 4'b0111;
    localparam logic [3:0] OP_PASS_B = 4'b1000;
    localparam logic [3:0] OP_PASS_A = 4'b1001;
    localparam logic [3:0] OP_ZERO   = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle issuing controller feeding ALU result back as B
module alu_sequencer #(
    parameter int REG_SIZE = alu_pkg::REG_SIZE,
    parameter int CNT_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [REG_SIZE-1:0] req_a,
    input  logic [REG_SIZE-1:0] req_b,
    input  logic [CNT_W-1:0]    req_count,
    output logic [3:0]          alu_sig,
    output logic [REG_SIZE-1:0] alu_a,
    output logic [REG_SIZE-1:0] alu_b,
    input  logic [REG_SIZE-1:0] alu_ac,
    input  logic                alu_z,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [REG_SIZE-1:0] rsp_data,
    output logic                rsp_z
);
    import alu_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_op;
    logic [REG_SIZE-1:0]   r_a;
    logic [REG_SIZE-1:0]   r_acc;
    logic                  r_zf;
    logic [CNT_W-1:0]      r_iter;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_accept;
    logic                  w_last;

    assign w_accept = (r_state == ST_IDLE) && req_valid;
    // r_cnt is never zero once loaded, so the subtraction cannot wrap
    assign w_last   = (r_iter == (r_cnt - CNT_ONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op   <= '0;
            r_a    <= '0;
            r_acc  <= '0;
            r_zf   <= 1'b0;
            r_iter <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_op   <= req_op;
            r_a    <= req_a;
            r_cnt  <= (req_count == '0) ? CNT_ONE : req_count;
            r_acc  <= req_b;
            r_iter <= '0;
        end else if (r_state == ST_EXEC) begin
            r_acc  <= alu_ac;
            r_zf   <= alu_z;
            r_iter <= r_iter + CNT_ONE;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_sig   = OP_PASS_B;
        alu_a     = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = ST_EXEC;
            end
            ST_EXEC: begin
                alu_sig = r_op;
                alu_a   = r_a;
                if (w_last) w_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign alu_b    = r_acc;
    assign rsp_data = r_acc;
    assign rsp_z    = r_zf;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed and randomized checks of alu_sequencer with a behavioural ALU
module tb_alu_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_op = 4'd0;
    logic [7:0] req_a = 8'd0;
    logic [7:0] req_b = 8'd0;
    logic [3:0] req_count = 4'd0;
    logic [3:0] alu_sig;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_ac;
    logic       alu_z;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_z;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.REG_SIZE(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_count(req_count),
        .alu_sig(alu_sig), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ac(alu_ac), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_z(rsp_z)
    );

    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_INC_B:  return 8'(b + 8'd1);
            OP_OR:     return a | b;
            OP_SUB:    return 8'(b - a);
            OP_XOR:    return a ^ b;
            OP_ONE:    return 8'd1;
            OP_AND:    return a & b;
            OP_ADD:    return 8'(a + b);
            OP_NOT_A:  return ~a;
            OP_PASS_B: return b;
            OP_PASS_A: return a;
            default:   return 8'd0;
        endcase
    endfunction

    always_comb begin
        alu_ac = alu_f(alu_sig, alu_a, alu_b);
        alu_z  = (alu_ac == 8'd0);
    end

    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] cnt, output bit ok);
        bit rdy;
        req_op = op; req_a = a; req_b = b; req_count = cnt; req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            rdy = req_ready;
            @(posedge clk); #1;
            if (rdy) begin ok = 1'b1; break; end
        end
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(input bit rnd, output logic [7:0] d, output logic zz,
                           output int lat, output bit ok);
        lat = 1; ok = 1'b0; d = 8'hxx; zz = 1'bx;
        for (int i = 0; i < 64; i++) begin
            if (rnd) rsp_ready = 1'($urandom_range(0, 1));
            if (rsp_valid && rsp_ready) begin
                d = rsp_data; zz = rsp_z; ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_hi_req_ready got=%0b exp=1", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_hi_rsp_valid got=%0b exp=0", rsp_valid); end
        total++; if (alu_sig !== 4'b1000) begin bad++; $display("FAIL rst_hi_alu_sig got=%0h exp=8", alu_sig); end
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%0b exp=1", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%0b exp=0", rsp_valid); end
        total++; if (rsp_data !== 8'h00) begin bad++; $display("FAIL rst_rsp_data got=%0h exp=0", rsp_data); end
        total++; if (rsp_z !== 1'b0) begin bad++; $display("FAIL rst_rsp_z got=%0b exp=0", rsp_z); end
        total++; if (alu_a !== 8'h00 || alu_b !== 8'h00) begin bad++; $display("FAIL rst_alu_ab got=%0h/%0h exp=0/0", alu_a, alu_b); end
    endtask

    task automatic test_add;
        bit ok; logic [7:0] d; logic zz; int lat;
        rsp_ready = 1'b1;
        send(OP_ADD, 8'd5, 8'd10, 4'd3, ok);
        total++; if (!ok) begin bad++; $display("FAIL add_accept got=0 exp=1"); end
        total++; if (alu_sig !== OP_ADD || alu_a !== 8'd5 || alu_b !== 8'd10)
            begin bad++; $display("FAIL add_exec_drive got=%0h/%0h/%0h exp=6/5/a", alu_sig, alu_a, alu_b); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL add_busy_ready got=%0b exp=0", req_ready); end
        get_rsp(1'b0, d, zz, lat, ok);
        total++; if (!ok || d !== 8'h19) begin bad++; $display("FAIL add_data got=%0h exp=19", d); end
        total++; if (zz !== 1'b0) begin bad++; $display("FAIL add_z got=%0b exp=0", zz); end
        total++; if (lat != 4) begin bad++; $display("FAIL add_latency got=%0d exp=4", lat); end
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            begin bad++; $display("FAIL add_idle got=%0b/%0b exp=0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_inc_wrap;
        bit ok; logic [7:0] d; logic zz; int lat;
        send(OP_INC_B, 8'd0, 8'hFE, 4'd2, ok);
        get_rsp(1'b0, d, zz, lat, ok);
        total++; if (!ok || d !== 8'h00) begin bad++; $display("FAIL inc_data got=%0h exp=0", d); end
        total++; if (zz !== 1'b1) begin bad++; $display("FAIL inc_z got=%0b exp=1", zz); end
        total++; if (lat != 3) begin bad++; $display("FAIL inc_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_count_zero;
        bit ok; logic [7:0] d; logic zz; int lat;
        send(OP_SUB, 8'd1, 8'd3, 4'd0, ok);
        get_rsp(1'b0, d, zz, lat, ok);
        total++; if (!ok || d !== 8'h02) begin bad++; $display("FAIL cnt0_data got=%0h exp=2", d); end
        total++; if (zz !== 1'b0) begin bad++; $display("FAIL cnt0_z got=%0b exp=0", zz); end
        total++; if (lat != 2) begin bad++; $display("FAIL cnt0_latency got=%0d exp=2", lat); end
    endtask

    task automatic test_backpressure;
        bit ok; logic [7:0] d; logic zz; int lat; bit seen;
        rsp_ready = 1'b0;
        send(OP_ONE, 8'h55, 8'hAA, 4'd1, ok);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        total++; if (!seen) begin bad++; $display("FAIL bp_valid_rise got=0 exp=1"); end
        req_op = OP_ADD; req_a = 8'd2; req_b = 8'd3; req_count = 4'd1; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h01 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_stall%0d got=v%0b d%0h r%0b exp=v1 d1 r0", i, rsp_valid, rsp_data, req_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            begin bad++; $display("FAIL bp_after_hs got=%0b/%0b exp=0/1", rsp_valid, req_ready); end
        @(posedge clk); #1;
        total++; if (alu_sig !== OP_ADD || req_ready !== 1'b0)
            begin bad++; $display("FAIL bp_second_accept got=%0h/%0b exp=6/0", alu_sig, req_ready); end
        req_valid = 1'b0;
        get_rsp(1'b0, d, zz, lat, ok);
        total++; if (!ok || d !== 8'h05) begin bad++; $display("FAIL bp_second_data got=%0h exp=5", d); end
    endtask

    task automatic test_reset_mid;
        bit ok; logic [7:0] d; logic zz; int lat; bit seen;
        rsp_ready = 1'b1;
        send(OP_ADD, 8'd1, 8'd0, 4'd8, ok);
        repeat (3) begin @(posedge clk); #1; end
        total++; if (alu_b !== 8'd3) begin bad++; $display("FAIL mid_acc got=%0h exp=3", alu_b); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_z !== 1'b0)
            begin bad++; $display("FAIL mid_rst_rsp got=r%0b v%0b d%0h z%0b exp=r1 v0 d0 z0", req_ready, rsp_valid, rsp_data, rsp_z); end
        total++; if (alu_sig !== 4'b1000 || alu_a !== 8'h00 || alu_b !== 8'h00)
            begin bad++; $display("FAIL mid_rst_alu got=%0h/%0h/%0h exp=8/0/0", alu_sig, alu_a, alu_b); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (seen) begin bad++; $display("FAIL mid_no_rsp got=1 exp=0"); end
        send(OP_ADD, 8'd2, 8'd2, 4'd1, ok);
        get_rsp(1'b0, d, zz, lat, ok);
        total++; if (!ok || d !== 8'h04) begin bad++; $display("FAIL mid_followup got=%0h exp=4", d); end
    endtask

    task automatic test_back_to_back;
        bit ok; logic [7:0] d; logic zz; int lat;
        logic [3:0] op, cnt; logic [7:0] a, b, acc; int eff; int nrsp;
        nrsp = 0;
        for (int n = 0; n < 16; n++) begin
            op  = 4'($urandom_range(0, 15));
            cnt = 4'($urandom_range(0, 15));
            a   = 8'($urandom);
            b   = 8'($urandom);
            eff = (cnt == 4'd0) ? 1 : int'(cnt);
            acc = b;
            for (int k = 0; k < eff; k++) acc = alu_f(op, a, acc);
            send(op, a, b, cnt, ok);
            get_rsp(1'b1, d, zz, lat, ok);
            if (ok) nrsp++;
            total++;
            if (d !== acc || zz !== (acc == 8'd0)) begin
                bad++;
                $display("FAIL b2b_%0d op=%0h cnt=%0d got=%0h/%0b exp=%0h/%0b", n, op, cnt, d, zz, acc, acc == 8'd0);
            end
        end
        total++; if (nrsp != 16) begin bad++; $display("FAIL b2b_rsp_count got=%0d exp=16", nrsp); end
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_add;
        test_inc_wrap;
        test_count_zero;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
